// File: rtl/mips32_pkg.sv
// Shared MIPS32 definitions: loader FSM encoding, instruction width and opcodes.
package mips32_pkg;

  localparam int INSTR_W = 32;

  localparam logic [5:0] ADD  = 6'h00;
  localparam logic [5:0] OR   = 6'h03;
  localparam logic [5:0] ADDI = 6'h0a;
  localparam logic [5:0] HLT  = 6'h3f;

  typedef enum logic [2:0] {
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } ldr_state_e;

endpackage

// File: rtl/mips32_word_packer.sv
// Packs accepted bytes MSB-first into instruction words; word_done strobes for one
// cycle after the 4th byte. Never stalls: every presented byte is taken.
module mips32_word_packer
  import mips32_pkg::*;
(
  input  logic               clk1,
  input  logic               rst_n,
  input  logic               byte_vld_i,
  input  logic [7:0]         byte_dat_i,
  output logic               last_byte_o,
  output logic               word_done_o,
  output logic [INSTR_W-1:0] word_o
);

  logic [1:0]         cnt_q;
  logic [INSTR_W-1:0] sh_q;
  logic               done_q;

  assign last_byte_o = byte_vld_i && (cnt_q == 2'd3);
  assign word_done_o = done_q;
  // The shift register holds the finished word until the next byte arrives,
  // which is never earlier than the edge ending the word_done cycle.
  assign word_o      = sh_q;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 2'd0;
      sh_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= last_byte_o;
      if (byte_vld_i) begin
        cnt_q <= cnt_q + 2'd1;
        sh_q  <= {sh_q[INSTR_W-9:0], byte_dat_i};
      end
    end
  end

endmodule

// File: rtl/mips32_prog_loader.sv
// Boot loader: length-prefixed byte frame -> instruction memory writes from word 0,
// XOR checksum check, then a one-cycle boot pulse; in_ready drops only in DONE/ERR.
module mips32_prog_loader
  import mips32_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic               clk1,
  input  logic               rst_n,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               load_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               cpu_hold,
  output logic               boot,
  output logic               err,
  output logic [ADDR_W:0]    words_loaded
);

  localparam logic [16:0] CAP = 17'd1 << ADDR_W;

  ldr_state_e         state_q, state_d;
  logic               run_q;
  logic               boot_q;
  logic [7:0]         len_hi_q;
  logic [15:0]        len_q;
  logic [7:0]         xor_q;
  logic [ADDR_W:0]    cnt_q;

  logic               acc;
  logic               pk_vld;
  logic               pk_last;
  logic               word_done;
  logic [INSTR_W-1:0] word;
  logic [15:0]        n_in;
  logic               len_last;
  logic               csum_ok;
  logic               reload;

  assign in_ready = run_q && (state_q inside {ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CSUM});
  assign acc      = in_valid && in_ready;
  assign pk_vld   = acc && (state_q == ST_DATA);
  assign n_in     = {len_hi_q, in_data};
  // cnt_q counts completed writes; it already equals the current word index
  // when that word's last byte arrives.
  assign len_last = (17'(cnt_q) + 17'd1) == {1'b0, len_q};
  assign csum_ok  = (in_data == xor_q);
  assign reload   = load_req && (state_q inside {ST_DONE, ST_ERR});

  mips32_word_packer u_packer (
    .clk1        (clk1),
    .rst_n       (rst_n),
    .byte_vld_i  (pk_vld),
    .byte_dat_i  (in_data),
    .last_byte_o (pk_last),
    .word_done_o (word_done),
    .word_o      (word)
  );

  assign mem_we       = word_done;
  assign mem_addr     = cnt_q[ADDR_W-1:0];
  assign mem_wdata    = word;
  assign words_loaded = cnt_q + {{ADDR_W{1'b0}}, word_done};
  assign cpu_hold     = (state_q != ST_DONE);
  assign err          = (state_q == ST_ERR);
  assign boot         = boot_q;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) state_q <= ST_LEN_HI;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_LEN_HI: if (acc) state_d = ST_LEN_LO;
      ST_LEN_LO: begin
        if (acc) begin
          if (n_in == 16'd0)              state_d = ST_CSUM;
          else if ({1'b0, n_in} > CAP)    state_d = ST_ERR;
          else                            state_d = ST_DATA;
        end
      end
      ST_DATA:   if (pk_last && len_last) state_d = ST_CSUM;
      ST_CSUM:   if (acc) state_d = csum_ok ? ST_DONE : ST_ERR;
      ST_DONE,
      ST_ERR:    if (load_req) state_d = ST_LEN_HI;
      default:   state_d = ST_LEN_HI;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      run_q    <= 1'b0;
      boot_q   <= 1'b0;
      len_hi_q <= 8'd0;
      len_q    <= 16'd0;
      xor_q    <= 8'd0;
      cnt_q    <= '0;
    end else begin
      run_q  <= 1'b1;
      boot_q <= (state_q == ST_CSUM) && acc && csum_ok;
      if (acc && (state_q != ST_CSUM)) xor_q <= xor_q ^ in_data;
      if (acc && (state_q == ST_LEN_HI)) len_hi_q <= in_data;
      if (acc && (state_q == ST_LEN_LO)) len_q <= n_in;
      if (word_done) cnt_q <= cnt_q + {{ADDR_W{1'b0}}, 1'b1};
      if (reload) begin
        xor_q <= 8'd0;
        cnt_q <= '0;
      end
    end
  end

endmodule
